hw_qsys_dbg_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port on-chip debug memory (the CPU's OCI RAM/debug register window) between several debug requesters, e.g. the JTAG debug-slave sysclk command path, the Avalon debug_mem slave and a trace unloader. It sits in the CPU clock domain, between the requesters and the memory port. It serialises accesses with one transaction outstanding at a time, returns read data to the owner, and optionally supports locked multi-access sequences.

---
 rtl/hw_qsys_dbg_mem_arbiter_if.sv | 33 +++
 rtl/hw_qsys_dbg_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_hw_qsys_dbg_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hw_qsys_dbg_mem_arbiter_if.sv
// Purpose : requester-side bus of the debug-memory arbiter (request, write, lock,
//           per-requester address/data in, one-hot grant/read-valid and shared read data out).
// Ports   : master = requesters (drive req/wr/lock/addr/wdata); slave = arbiter.
interface hw_qsys_dbg_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);

  // Requester -> arbiter, packed with requester i at [i*W +: W].
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        wr;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;

  // Arbiter -> requester. gnt/rvalid are one-hot single-cycle pulses;
  // rdata is shared and only meaningful alongside rvalid.
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, wr, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/hw_qsys_dbg_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port debug memory between NUM_REQ requesters.
// Latency : gnt/mem_en 1 cycle after req sampled in IDLE; read data + rvalid 3 cycles after; writes every 2 cycles.
// Backpr. : one access outstanding; requests stay pending (level req) until granted, none dropped.
//
// Ports   : clk, reset (synchronous, active-high)
//           bus       - requester side (req/wr/lock/addr/wdata in, gnt/rvalid/rdata out)
//           busy      - arbiter is not in IDLE
//           mem_*     - single-port memory strobe/write/address/data; mem_rdata valid 1 cycle after mem_en
// Option  : define DBG_ARB_LOCK_EN to honour lock[] (owner keeps exclusive access across accesses);
//           otherwise lock[] is ignored and no owner state exists.
module hw_qsys_dbg_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hw_qsys_dbg_mem_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;        // last winner; also owner of the in-flight access
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  // Requests allowed to compete in the current IDLE cycle.
  logic [NUM_REQ-1:0] elig;

  // Round-robin search result.
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

`ifdef DBG_ARB_LOCK_EN
  // The owner is always the last winner, so ptr_q doubles as the owner index
  // and only a valid flag is needed.
  logic lock_q, lock_d;
  logic lock_hold;

  // While locked, the owner keeps exclusivity as long as it either requests
  // again or still asserts lock. An owner that requests with lock low gets
  // this final access and the lock falls away with it; an owner that drops
  // both releases immediately and everyone competes in the same cycle.
  always_comb begin
    elig      = bus.req;
    lock_hold = 1'b0;
    if (lock_q && (bus.req[ptr_q] || bus.lock[ptr_q])) begin
      lock_hold = 1'b1;
      elig      = bus.req & (NUM_REQ'(1) << ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;

  always_comb begin
    elig = bus.req;
  end
`endif

  // First eligible requester at or after ptr+1, wrapping at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef DBG_ARB_LOCK_EN
    lock_d      = lock_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef DBG_ARB_LOCK_EN
        if (!lock_hold) begin
          lock_d = 1'b0;
        end
`endif
        if (win_vld) begin
          state_d        = ISSUE;
          ptr_d          = win_idx;
          gnt_d[win_idx] = 1'b1;
          mem_en_d       = 1'b1;
          mem_wr_d       = bus.wr[win_idx];
          mem_addr_d     = bus.addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d    = bus.wdata[int'(win_idx)*DATA_W +: DATA_W];
`ifdef DBG_ARB_LOCK_EN
          lock_d         = bus.lock[win_idx];
`endif
        end
      end

      // Memory strobe is on the pins this cycle; writes complete here.
      ISSUE: begin
        state_d = mem_wr_q ? IDLE : WAIT;
      end

      // Read data returns one cycle after the strobe.
      WAIT: begin
        rdata_d         = mem_rdata;
        rvalid_d[ptr_q] = 1'b1;
        state_d         = RESP;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered copy of "state != IDLE" so busy lines up with the state.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign busy       = busy_q;
  assign mem_en     = mem_en_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Structural invariants: at most one grant / read-valid, and the memory
  // strobe coincides exactly with the grant pulse.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
  a_rv_onehot0  : assert property (@(posedge clk) disable iff (reset) $onehot0(rvalid_q));
  a_en_with_gnt : assert property (@(posedge clk) disable iff (reset) (mem_en_q == (gnt_q != '0)));

endmodule

// File: tb/tb_hw_qsys_dbg_mem_arbiter.sv
module tb_hw_qsys_dbg_mem_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hw_qsys_dbg_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic              busy, mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  hw_qsys_dbg_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port memory: read data one cycle after the strobe.
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  // Reference view of memory contents, updated in grant order by the model.
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int mdl_ptr = NUM_REQ - 1;

  // Round-robin rule: first set bit of m at or after p+1, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int p);
    logic [NUM_REQ-1:0] sh;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sh = m >> ((p + k) % NUM_REQ);
      if (sh[0]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic drive_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic lk);
    bus.wr[i]                     = w;
    bus.addr[i*ADDR_W +: ADDR_W]  = a;
    bus.wdata[i*DATA_W +: DATA_W] = d;
    bus.lock[i]                   = lk;
    bus.req[i]                    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.wr   = '0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    mdl_ptr = NUM_REQ - 1;
  endtask

  task automatic test_reset();
    logic [2*NUM_REQ+DATA_W+3+ADDR_W+DATA_W-1:0] outs;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      outs = {bus.gnt, bus.rvalid, bus.rdata, busy, mem_en, mem_wr, mem_addr, mem_wdata};
      n_chk++;
      if (outs !== '0) $display("FAIL reset_idle cycle %0d: got %0h want 0", c, outs);
      else n_pass++;
    end
  endtask

  task automatic test_single_read();
    do_reset();
    drive_req(2, 1'b0, 8'h15, '0, 1'b0);
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0100) $display("FAIL read_gnt: got %b want 0100", bus.gnt); else n_pass++;
    n_chk++; if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 8'h15})
      $display("FAIL read_mem: got en=%b wr=%b addr=%h want 1/0/15", mem_en, mem_wr, mem_addr); else n_pass++;
    bus.req[2] = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.rvalid !== 4'b0000) $display("FAIL read_early_rvalid: got %b want 0000", bus.rvalid); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.rvalid !== 4'b0100) $display("FAIL read_rvalid: got %b want 0100", bus.rvalid); else n_pass++;
    n_chk++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", bus.rdata); else n_pass++;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL read_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_rr_writes();
    logic [DATA_W-1:0] wd [NUM_REQ];
    logic [ADDR_W-1:0] ad [NUM_REQ];
    int exp, last_t, grants;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      ad[i] = ADDR_W'($urandom_range(32, 63));
      wd[i] = $urandom;
      drive_req(i, 1'b1, ad[i], wd[i], 1'b0);
    end
    grants = 0;
    last_t = -1;
    for (int t = 1; t <= 60 && grants < 8; t++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        exp = rr_pick('1, mdl_ptr);
        n_chk++; if (bus.gnt !== (NUM_REQ'(1) << exp))
          $display("FAIL rr_order grant %0d: got %b want idx %0d", grants, bus.gnt, exp); else n_pass++;
        n_chk++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, ad[exp], wd[exp]})
          $display("FAIL rr_wdata grant %0d: got %b/%h/%h want 1/%h/%h", grants, mem_wr, mem_addr, mem_wdata, ad[exp], wd[exp]);
        else n_pass++;
        if (last_t >= 0) begin
          n_chk++; if (t - last_t != 2) $display("FAIL rr_spacing grant %0d: got %0d want 2", grants, t - last_t); else n_pass++;
        end
        last_t = t;
        mdl_ptr = exp;
        ref_mem[ad[exp]] = wd[exp];
        ad[exp] = ADDR_W'($urandom_range(32, 63));
        wd[exp] = $urandom;
        drive_req(exp, 1'b1, ad[exp], wd[exp], 1'b0);
        grants++;
      end
    end
    n_chk++; if (grants != 8) $display("FAIL rr_timeout: got %0d grants want 8", grants); else n_pass++;
    bus.req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [2*NUM_REQ+DATA_W+3+ADDR_W+DATA_W-1:0] outs;
    do_reset();
    drive_req(2, 1'b0, ADDR_W'($urandom), '0, 1'b0);
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0100) $display("FAIL rst_read_gnt: got %b want 0100", bus.gnt); else n_pass++;
    bus.req[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    outs = {bus.gnt, bus.rvalid, bus.rdata, busy, mem_en, mem_wr, mem_addr, mem_wdata};
    n_chk++; if (outs !== '0) $display("FAIL rst_mid_outputs: got %0h want 0", outs); else n_pass++;
    reset = 1'b0;
    drive_req(0, 1'b0, 8'h01, '0, 1'b0);
    drive_req(2, 1'b0, 8'h02, '0, 1'b0);
    @(negedge clk);
    n_chk++; if ({bus.gnt, bus.rvalid} !== {4'b0001, 4'b0000})
      $display("FAIL rst_next_gnt: got gnt=%b rvalid=%b want 0001/0000", bus.gnt, bus.rvalid); else n_pass++;
    bus.req = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    do_reset();
    a = ADDR_W'($urandom);
    drive_req(0, 1'b0, a, '0, 1'b0);
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0001) $display("FAIL b2b_gnt0: got %b want 0001", bus.gnt); else n_pass++;
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bus.rvalid, bus.rdata} !== {4'b0001, ref_mem[a]})
      $display("FAIL b2b_rv0: got %b/%h want 0001/%h", bus.rvalid, bus.rdata, ref_mem[a]); else n_pass++;
    a = ADDR_W'($urandom);
    drive_req(0, 1'b0, a, '0, 1'b0);
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0000) $display("FAIL b2b_gap: got %b want 0000", bus.gnt); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0001) $display("FAIL b2b_regrant: got %b want 0001", bus.gnt); else n_pass++;
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bus.rvalid, bus.rdata} !== {4'b0001, ref_mem[a]})
      $display("FAIL b2b_rv1: got %b/%h want 0001/%h", bus.rvalid, bus.rdata, ref_mem[a]); else n_pass++;
    drive_req(0, 1'b0, 8'h10, '0, 1'b0);
    drive_req(1, 1'b0, 8'h11, '0, 1'b0);
    repeat (2) @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0010) $display("FAIL b2b_other_wins: got %b want 0010", bus.gnt); else n_pass++;
    bus.req[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (bus.gnt !== 4'b0001) $display("FAIL b2b_pending0: got %b want 0001", bus.gnt); else n_pass++;
    bus.req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock();
    int seq[$];
    int exp_seq[$];
    int n1;
`ifdef DBG_ARB_LOCK_EN
    exp_seq = '{1, 1, 1, 1, 3};
`else
    exp_seq = '{1, 3, 1, 3, 1, 3, 1, 3};
`endif
    do_reset();
    n1 = 0;
    drive_req(1, 1'b0, 8'h20, '0, 1'b1);
    drive_req(3, 1'b0, 8'h30, '0, 1'b0);
    for (int t = 0; t < 120 && seq.size() < exp_seq.size(); t++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        seq.push_back(($countones(bus.gnt) == 1) ? $clog2(bus.gnt) : -1);
        if (bus.gnt[1]) begin
          bus.req[1] = 1'b0;
          n1++;
        end
      end
      if (bus.rvalid[1] && n1 < 4) drive_req(1, 1'b0, 8'h20, '0, (n1 < 3));
    end
    n_chk++; if (seq.size() != exp_seq.size())
      $display("FAIL lock_timeout: got %0d grants want %0d", seq.size(), exp_seq.size()); else n_pass++;
    for (int i = 0; i < seq.size() && i < exp_seq.size(); i++) begin
      n_chk++; if (seq[i] != exp_seq[i])
        $display("FAIL lock_order grant %0d: got %0d want %0d", i, seq[i], exp_seq[i]); else n_pass++;
    end
    bus.req  = '0;
    bus.lock = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] mask, exp_gnt, exp_rv;
    logic               r_wr [NUM_REQ];
    logic [ADDR_W-1:0]  r_ad [NUM_REQ];
    logic [DATA_W-1:0]  r_wd [NUM_REQ];
    logic [DATA_W-1:0]  rd_exp;
    int next_ok, rd_t, rd_own, w;
    do_reset();
    next_ok = 1;
    rd_t    = -1;
    rd_own  = 0;
    rd_exp  = '0;
    w       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_wr[i] = 1'b0; r_ad[i] = '0; r_wd[i] = '0;
    end
    for (int t = 1; t <= 400; t++) begin
      mask = bus.req;
      @(negedge clk);
      exp_gnt = '0;
      if (t >= next_ok && mask != '0) begin
        w       = rr_pick(mask, mdl_ptr);
        exp_gnt = NUM_REQ'(1) << w;
        mdl_ptr = w;
        if (r_wr[w]) begin
          ref_mem[r_ad[w]] = r_wd[w];
          next_ok = t + 2;
        end else begin
          rd_exp  = ref_mem[r_ad[w]];
          rd_own  = w;
          rd_t    = t + 2;
          next_ok = t + 4;
        end
        bus.req[w] = 1'b0;
      end
      exp_rv = (t == rd_t) ? (NUM_REQ'(1) << rd_own) : '0;
      n_chk++; if (bus.gnt !== exp_gnt) $display("FAIL rnd_gnt t=%0d: got %b want %b", t, bus.gnt, exp_gnt); else n_pass++;
      n_chk++; if (bus.rvalid !== exp_rv) $display("FAIL rnd_rvalid t=%0d: got %b want %b", t, bus.rvalid, exp_rv); else n_pass++;
      n_chk++; if (busy !== (t <= next_ok - 2)) $display("FAIL rnd_busy t=%0d: got %b want %b", t, busy, (t <= next_ok - 2)); else n_pass++;
      if (t == rd_t) begin
        n_chk++; if (bus.rdata !== rd_exp) $display("FAIL rnd_rdata t=%0d: got %h want %h", t, bus.rdata, rd_exp); else n_pass++;
      end
      if (exp_gnt != '0) begin
        n_chk++; if ({mem_wr, mem_addr} !== {r_wr[w], r_ad[w]})
          $display("FAIL rnd_mem t=%0d: got %b/%h want %b/%h", t, mem_wr, mem_addr, r_wr[w], r_ad[w]); else n_pass++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req[i] && !exp_gnt[i] && $urandom_range(0, 2) == 0) begin
          r_wr[i] = 1'($urandom_range(0, 1));
          r_ad[i] = ADDR_W'($urandom_range(0, 15));
          r_wd[i] = $urandom;
          drive_req(i, r_wr[i], r_ad[i], r_wd[i], 1'b0);
        end
      end
    end
    bus.req = '0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h15]     = 32'hDEADBEEF;
    ref_mem[8'h15] = 32'hDEADBEEF;
    bus.req   = '0;
    bus.wr    = '0;
    bus.lock  = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    test_reset();
    test_single_read();
    test_rr_writes();
    test_reset_mid_read();
    test_back_to_back();
    test_lock();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
